// File: rtl/ifu_fetch_flush_if.sv
// Fetch-unit bundle: commit flush, instruction memory request/response, and decode output.
// The master modport is the fetch unit; slave is the surrounding pipeline/memory.
`ifndef PC_SIZE
`define PC_SIZE 32
`endif

interface ifu_fetch_flush_if;
  logic                pipe_flush_req;
  logic [`PC_SIZE-1:0] pipe_flush_add_op1;
  logic [`PC_SIZE-1:0] pipe_flush_add_op2;
  logic                pipe_flush_ack;
  logic                ifu_req_valid;
  logic                ifu_req_ready;
  logic [`PC_SIZE-1:0] ifu_req_pc;
  logic                ifu_rsp_valid;
  logic                ifu_rsp_ready;
  logic [31:0]         ifu_rsp_instr;
  logic                ifu_o_valid;
  logic                ifu_o_ready;
  logic [`PC_SIZE-1:0] ifu_o_pc;
  logic [31:0]         ifu_o_ir;

  modport master (
    input  pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2,
           ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, ifu_o_ready,
    output pipe_flush_ack, ifu_req_valid, ifu_req_pc, ifu_rsp_ready,
           ifu_o_valid, ifu_o_pc, ifu_o_ir
  );

  modport slave (
    output pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2,
           ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, ifu_o_ready,
    input  pipe_flush_ack, ifu_req_valid, ifu_req_pc, ifu_rsp_ready,
           ifu_o_valid, ifu_o_pc, ifu_o_ir
  );
endinterface

// File: rtl/ifu_fetch_flush.sv
// Single-outstanding instruction fetch with commit-driven flush; a fetch in flight
// when a flush lands is killed and its response silently drained.
`ifndef PC_SIZE
`define PC_SIZE 32
`endif

module ifu_fetch_flush #(
  parameter logic [`PC_SIZE-1:0] RESET_PC = {`PC_SIZE{1'b0}}
) (
  input  logic clk,
  input  logic rst_n,
  ifu_fetch_flush_if.master bus
);
  localparam int PW = `PC_SIZE;

  typedef enum logic [1:0] {S_RST, S_IDLE, S_WAIT, S_KILL} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   pc_q, pc_d;
  logic [PW-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   flush_tgt;
  logic            flush_hs, req_hs, rsp_hs;

  // Carry out of the add is intentionally dropped.
  assign flush_tgt = bus.pipe_flush_add_op1 + bus.pipe_flush_add_op2;

  assign bus.pipe_flush_ack = (state_q != S_RST);
  assign bus.ifu_req_valid  = (state_q == S_IDLE) & ~bus.pipe_flush_req;
  assign bus.ifu_req_pc     = pc_q;
  assign bus.ifu_o_valid    = (state_q == S_WAIT) & bus.ifu_rsp_valid & ~bus.pipe_flush_req;
  // A flush in WAIT drains the response so it never reaches decode.
  assign bus.ifu_rsp_ready  = ((state_q == S_WAIT) & (bus.ifu_o_ready | bus.pipe_flush_req))
                            | (state_q == S_KILL);
  assign bus.ifu_o_pc       = fetch_pc_q;
  assign bus.ifu_o_ir       = bus.ifu_rsp_instr;

  assign flush_hs = bus.pipe_flush_req & bus.pipe_flush_ack;
  assign req_hs   = bus.ifu_req_valid & bus.ifu_req_ready;
  assign rsp_hs   = bus.ifu_rsp_valid & bus.ifu_rsp_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    if (flush_hs) pc_d = flush_tgt;
    case (state_q)
      S_RST:  state_d = S_IDLE;
      S_IDLE: begin
        if (req_hs) begin
          fetch_pc_d = pc_q;
          pc_d       = pc_q + PW'(4);
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush_hs)    state_d = bus.ifu_rsp_valid ? S_IDLE : S_KILL;
        else if (rsp_hs) state_d = S_IDLE;
      end
      S_KILL: begin
        if (bus.ifu_rsp_valid) state_d = S_IDLE;
      end
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RST;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end
endmodule

// File: tb/tb_ifu_fetch_flush.sv
// Directed scenarios plus a randomized run against a transaction-level fetch model.
`ifndef PC_SIZE
`define PC_SIZE 32
`endif

module tb_ifu_fetch_flush;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  ifu_fetch_flush_if bus();

  ifu_fetch_flush #(.RESET_PC(32'h0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic quiet();
    bus.pipe_flush_req = 0; bus.pipe_flush_add_op1 = '0; bus.pipe_flush_add_op2 = '0;
    bus.ifu_req_ready = 0; bus.ifu_rsp_valid = 0; bus.ifu_rsp_instr = '0; bus.ifu_o_ready = 0;
  endtask

  task automatic test_reset();
    quiet();
    bus.pipe_flush_req = 1;
    rst_n = 0;
    #13;
    n_cmp++; if (bus.ifu_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid got %h want 0", bus.ifu_req_valid); end
    n_cmp++; if (bus.pipe_flush_ack !== 1'b0) begin n_err++; $display("FAIL rst_ack got %h want 0", bus.pipe_flush_ack); end
    n_cmp++; if (bus.ifu_rsp_ready !== 1'b0) begin n_err++; $display("FAIL rst_rsp_ready got %h want 0", bus.ifu_rsp_ready); end
    n_cmp++; if (bus.ifu_o_valid !== 1'b0) begin n_err++; $display("FAIL rst_o_valid got %h want 0", bus.ifu_o_valid); end
    n_cmp++; if (bus.ifu_o_pc !== 32'h0) begin n_err++; $display("FAIL rst_o_pc got %h want 0", bus.ifu_o_pc); end
    tick();
    rst_n = 1;
    #1;
    n_cmp++; if (bus.pipe_flush_ack !== 1'b0) begin n_err++; $display("FAIL srst_ack got %h want 0", bus.pipe_flush_ack); end
    n_cmp++; if (bus.ifu_req_valid !== 1'b0) begin n_err++; $display("FAIL srst_req_valid got %h want 0", bus.ifu_req_valid); end
    bus.pipe_flush_req = 0;
    tick();
    n_cmp++; if (bus.ifu_req_valid !== 1'b1) begin n_err++; $display("FAIL idle_req_valid got %h want 1", bus.ifu_req_valid); end
    n_cmp++; if (bus.ifu_req_pc !== 32'h0) begin n_err++; $display("FAIL idle_req_pc got %h want 0", bus.ifu_req_pc); end
    n_cmp++; if (bus.pipe_flush_ack !== 1'b1) begin n_err++; $display("FAIL idle_ack got %h want 1", bus.pipe_flush_ack); end
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 3; k++) begin
      bus.ifu_req_ready = 1; bus.ifu_o_ready = 1; #1;
      n_cmp++; if (bus.ifu_req_pc !== 32'(4*k)) begin n_err++; $display("FAIL seq_req_pc got %h want %h", bus.ifu_req_pc, 32'(4*k)); end
      tick();
      bus.ifu_rsp_valid = 1; bus.ifu_rsp_instr = 32'h1000 + 32'(k); #1;
      n_cmp++; if (bus.ifu_req_valid !== 1'b0) begin n_err++; $display("FAIL seq_wait_req_valid got %h want 0", bus.ifu_req_valid); end
      n_cmp++; if (bus.ifu_o_valid !== 1'b1) begin n_err++; $display("FAIL seq_o_valid got %h want 1", bus.ifu_o_valid); end
      n_cmp++; if (bus.ifu_o_pc !== 32'(4*k)) begin n_err++; $display("FAIL seq_o_pc got %h want %h", bus.ifu_o_pc, 32'(4*k)); end
      n_cmp++; if (bus.ifu_o_ir !== 32'h1000 + 32'(k)) begin n_err++; $display("FAIL seq_o_ir got %h want %h", bus.ifu_o_ir, 32'h1000 + 32'(k)); end
      tick();
      bus.ifu_rsp_valid = 0;
    end
  endtask

  task automatic test_flush_kill();
    quiet();
    bus.pipe_flush_req = 1; bus.pipe_flush_add_op1 = 32'h10; #1;
    n_cmp++; if (bus.ifu_req_valid !== 1'b0) begin n_err++; $display("FAIL fk_idle_req_valid got %h want 0", bus.ifu_req_valid); end
    tick();
    quiet(); bus.ifu_req_ready = 1; #1;
    n_cmp++; if (bus.ifu_req_pc !== 32'h10) begin n_err++; $display("FAIL fk_req_pc got %h want 10", bus.ifu_req_pc); end
    tick();
    quiet();
    bus.pipe_flush_req = 1; bus.pipe_flush_add_op1 = 32'h100; bus.pipe_flush_add_op2 = 32'h20; #1;
    n_cmp++; if (bus.pipe_flush_ack !== 1'b1) begin n_err++; $display("FAIL fk_ack got %h want 1", bus.pipe_flush_ack); end
    tick();
    quiet(); bus.ifu_o_ready = 1; #1;
    n_cmp++; if (bus.ifu_rsp_ready !== 1'b1) begin n_err++; $display("FAIL fk_kill_rsp_ready got %h want 1", bus.ifu_rsp_ready); end
    n_cmp++; if (bus.ifu_req_valid !== 1'b0) begin n_err++; $display("FAIL fk_kill_req_valid got %h want 0", bus.ifu_req_valid); end
    tick();
    bus.ifu_rsp_valid = 1; bus.ifu_rsp_instr = 32'hDEAD; #1;
    n_cmp++; if (bus.ifu_o_valid !== 1'b0) begin n_err++; $display("FAIL fk_drop_o_valid got %h want 0", bus.ifu_o_valid); end
    tick();
    bus.ifu_rsp_valid = 0; #1;
    n_cmp++; if (bus.ifu_req_pc !== 32'h120) begin n_err++; $display("FAIL fk_next_pc got %h want 120", bus.ifu_req_pc); end
    n_cmp++; if (bus.ifu_req_valid !== 1'b1) begin n_err++; $display("FAIL fk_next_req_valid got %h want 1", bus.ifu_req_valid); end
  endtask

  task automatic test_flush_coincident();
    quiet(); bus.ifu_req_ready = 1;
    tick();
    quiet();
    bus.pipe_flush_req = 1; bus.pipe_flush_add_op1 = 32'h40; bus.pipe_flush_add_op2 = 32'h4;
    bus.ifu_rsp_valid = 1; bus.ifu_rsp_instr = 32'hBEEF; #1;
    n_cmp++; if (bus.ifu_rsp_ready !== 1'b1) begin n_err++; $display("FAIL co_rsp_ready got %h want 1", bus.ifu_rsp_ready); end
    n_cmp++; if (bus.ifu_o_valid !== 1'b0) begin n_err++; $display("FAIL co_o_valid got %h want 0", bus.ifu_o_valid); end
    tick();
    quiet(); #1;
    n_cmp++; if (bus.ifu_req_valid !== 1'b1) begin n_err++; $display("FAIL co_req_valid got %h want 1", bus.ifu_req_valid); end
    n_cmp++; if (bus.ifu_req_pc !== 32'h44) begin n_err++; $display("FAIL co_req_pc got %h want 44", bus.ifu_req_pc); end
  endtask

  task automatic test_double_flush();
    quiet(); bus.ifu_req_ready = 1;
    tick();
    quiet(); bus.pipe_flush_req = 1; bus.pipe_flush_add_op1 = 32'h80;
    tick();
    bus.pipe_flush_add_op1 = 32'h200;
    tick();
    bus.pipe_flush_add_op1 = 32'h300; #1;
    n_cmp++; if (bus.pipe_flush_ack !== 1'b1) begin n_err++; $display("FAIL df_ack got %h want 1", bus.pipe_flush_ack); end
    tick();
    quiet(); bus.ifu_o_ready = 1; bus.ifu_rsp_valid = 1; bus.ifu_rsp_instr = 32'h1111; #1;
    n_cmp++; if (bus.ifu_o_valid !== 1'b0) begin n_err++; $display("FAIL df_drop_o_valid got %h want 0", bus.ifu_o_valid); end
    n_cmp++; if (bus.ifu_req_valid !== 1'b0) begin n_err++; $display("FAIL df_kill_req_valid got %h want 0", bus.ifu_req_valid); end
    tick();
    bus.ifu_rsp_valid = 0; bus.ifu_req_ready = 1; #1;
    n_cmp++; if (bus.ifu_req_pc !== 32'h300) begin n_err++; $display("FAIL df_req_pc got %h want 300", bus.ifu_req_pc); end
    tick();
    bus.ifu_req_ready = 0; bus.ifu_rsp_valid = 1; bus.ifu_rsp_instr = 32'h2222; #1;
    n_cmp++; if (bus.ifu_o_valid !== 1'b1) begin n_err++; $display("FAIL df_deliver_o_valid got %h want 1", bus.ifu_o_valid); end
    n_cmp++; if (bus.ifu_o_pc !== 32'h300) begin n_err++; $display("FAIL df_deliver_o_pc got %h want 300", bus.ifu_o_pc); end
    tick();
    bus.ifu_rsp_valid = 0;
  endtask

  task automatic test_wrap();
    quiet(); bus.pipe_flush_req = 1; bus.pipe_flush_add_op1 = 32'hFFFF_FFF0; bus.pipe_flush_add_op2 = 32'hC;
    tick();
    quiet(); bus.ifu_req_ready = 1; #1;
    n_cmp++; if (bus.ifu_req_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wr_req_pc got %h want fffffffc", bus.ifu_req_pc); end
    tick();
    quiet(); bus.ifu_o_ready = 1; bus.ifu_rsp_valid = 1; #1;
    n_cmp++; if (bus.ifu_o_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wr_o_pc got %h want fffffffc", bus.ifu_o_pc); end
    tick();
    quiet(); #1;
    n_cmp++; if (bus.ifu_req_pc !== 32'h0) begin n_err++; $display("FAIL wr_inc_wrap got %h want 0", bus.ifu_req_pc); end
    bus.pipe_flush_req = 1; bus.pipe_flush_add_op1 = 32'hFFFF_FFF0; bus.pipe_flush_add_op2 = 32'h20;
    tick();
    quiet(); #1;
    n_cmp++; if (bus.ifu_req_pc !== 32'h10) begin n_err++; $display("FAIL wr_tgt_wrap got %h want 10", bus.ifu_req_pc); end
  endtask

  task automatic test_reset_midfetch();
    quiet(); bus.ifu_req_ready = 1;
    tick();
    quiet(); bus.ifu_rsp_valid = 1; bus.ifu_rsp_instr = 32'h3333;
    tick();
    n_cmp++; if (bus.ifu_o_valid !== 1'b1) begin n_err++; $display("FAIL rm_hold_o_valid got %h want 1", bus.ifu_o_valid); end
    n_cmp++; if (bus.ifu_o_pc !== 32'h10) begin n_err++; $display("FAIL rm_hold_o_pc got %h want 10", bus.ifu_o_pc); end
    #2 rst_n = 0; #1;
    n_cmp++; if (bus.ifu_o_valid !== 1'b0) begin n_err++; $display("FAIL rm_async_o_valid got %h want 0", bus.ifu_o_valid); end
    n_cmp++; if (bus.ifu_rsp_ready !== 1'b0) begin n_err++; $display("FAIL rm_async_rsp_ready got %h want 0", bus.ifu_rsp_ready); end
    n_cmp++; if (bus.ifu_o_pc !== 32'h0) begin n_err++; $display("FAIL rm_async_o_pc got %h want 0", bus.ifu_o_pc); end
    tick();
    rst_n = 1; #1;
    n_cmp++; if (bus.ifu_rsp_ready !== 1'b0) begin n_err++; $display("FAIL rm_srst_rsp_ready got %h want 0", bus.ifu_rsp_ready); end
    tick();
    n_cmp++; if (bus.ifu_rsp_ready !== 1'b0) begin n_err++; $display("FAIL rm_stale_rsp_ready got %h want 0", bus.ifu_rsp_ready); end
    n_cmp++; if (bus.ifu_req_valid !== 1'b1) begin n_err++; $display("FAIL rm_req_valid got %h want 1", bus.ifu_req_valid); end
    n_cmp++; if (bus.ifu_req_pc !== 32'h0) begin n_err++; $display("FAIL rm_req_pc got %h want 0", bus.ifu_req_pc); end
    tick();
    n_cmp++; if (bus.ifu_req_pc !== 32'h0) begin n_err++; $display("FAIL rm_stale_ignored got %h want 0", bus.ifu_req_pc); end
    quiet();
  endtask

  // Model: a stream of PCs advancing by 4, redirected by flushes; one fetch in
  // flight at a time, which a flush marks dead unless its response is present.
  task automatic test_random();
    logic [31:0] mpc = 32'h0, opc = 32'h0, rinstr = 32'h0;
    bit out = 0, killed = 0, rsp_on = 0;
    int lat = 0;
    bit fl, e_req, e_rrdy, e_oval;
    for (int c = 0; c < 3000; c++) begin
      if (out && !rsp_on) begin
        if (lat == 0) begin rsp_on = 1; rinstr = $urandom; end
        else lat--;
      end
      fl = ($urandom_range(0, 7) == 0);
      bus.pipe_flush_req     = fl;
      bus.pipe_flush_add_op1 = $urandom;
      bus.pipe_flush_add_op2 = $urandom;
      bus.ifu_req_ready      = ($urandom_range(0, 2) != 0);
      bus.ifu_o_ready        = ($urandom_range(0, 3) != 0);
      bus.ifu_rsp_valid      = rsp_on;
      bus.ifu_rsp_instr      = rinstr;
      #1;
      e_req  = !out && !fl;
      e_rrdy = out && (killed || bus.ifu_o_ready || fl);
      e_oval = out && !killed && rsp_on && !fl;
      n_cmp++; if (bus.pipe_flush_ack !== 1'b1) begin n_err++; $display("FAIL rnd_ack c=%0d got %h want 1", c, bus.pipe_flush_ack); end
      n_cmp++; if (bus.ifu_req_valid !== e_req) begin n_err++; $display("FAIL rnd_req_valid c=%0d got %h want %h", c, bus.ifu_req_valid, e_req); end
      n_cmp++; if (bus.ifu_rsp_ready !== e_rrdy) begin n_err++; $display("FAIL rnd_rsp_ready c=%0d got %h want %h", c, bus.ifu_rsp_ready, e_rrdy); end
      n_cmp++; if (bus.ifu_o_valid !== e_oval) begin n_err++; $display("FAIL rnd_o_valid c=%0d got %h want %h", c, bus.ifu_o_valid, e_oval); end
      if (e_req) begin
        n_cmp++; if (bus.ifu_req_pc !== mpc) begin n_err++; $display("FAIL rnd_req_pc c=%0d got %h want %h", c, bus.ifu_req_pc, mpc); end
      end
      if (e_oval) begin
        n_cmp++; if (bus.ifu_o_pc !== opc) begin n_err++; $display("FAIL rnd_o_pc c=%0d got %h want %h", c, bus.ifu_o_pc, opc); end
        n_cmp++; if (bus.ifu_o_ir !== rinstr) begin n_err++; $display("FAIL rnd_o_ir c=%0d got %h want %h", c, bus.ifu_o_ir, rinstr); end
      end
      if (fl) begin
        mpc = bus.pipe_flush_add_op1 + bus.pipe_flush_add_op2;
        if (out) begin
          if (rsp_on) begin out = 0; rsp_on = 0; end
          else killed = 1;
        end
      end else if (!out) begin
        if (bus.ifu_req_ready) begin
          out = 1; killed = 0; opc = mpc; mpc = mpc + 32'd4; lat = $urandom_range(0, 3);
        end
      end else if (rsp_on && e_rrdy) begin
        out = 0; rsp_on = 0;
      end
      tick();
    end
    quiet();
  endtask

  initial begin
    quiet();
    test_reset();
    test_sequential();
    test_flush_kill();
    test_flush_coincident();
    test_double_flush();
    test_wrap();
    test_reset_midfetch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ifu_fetch_flush.md
IFU_FETCH_FLUSH -- requirements
Module: ifu_fetch_flush

Interface
REQ-001 Parameter RESET_PC, default {`PC_SIZE{1'b0}}: first fetch address after reset.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 pipe_flush_req  input  1  flush request from commit (branch mispredict).
REQ-005 pipe_flush_add_op1  input  `PC_SIZE  flush target operand 1.
REQ-006 pipe_flush_add_op2  input  `PC_SIZE  flush target operand 2.
REQ-007 pipe_flush_ack  output  1  flush accepted this cycle.
REQ-008 ifu_req_valid  output  1  fetch request to instruction memory.
REQ-009 ifu_req_ready  input  1  memory accepts request.
REQ-010 ifu_req_pc  output  `PC_SIZE  fetch address.
REQ-011 ifu_rsp_valid  input  1  instruction response valid.
REQ-012 ifu_rsp_ready  output  1  block accepts response.
REQ-013 ifu_rsp_instr  input  32  fetched instruction.
REQ-014 ifu_o_valid  output  1  instruction to decode valid.
REQ-015 ifu_o_ready  input  1  decode accepts.
REQ-016 ifu_o_pc  output  `PC_SIZE  PC of delivered instruction.
REQ-017 ifu_o_ir  output  32  delivered instruction.

Function
REQ-018 Registers: state (S_RST, S_IDLE, S_WAIT, S_KILL), pc_r (next fetch PC), fetch_pc_r (PC of outstanding fetch); at most one fetch outstanding.
REQ-019 Flush target = pipe_flush_add_op1 + pipe_flush_add_op2, truncated to `PC_SIZE bits (carry discarded).
REQ-020 pipe_flush_ack = (state != S_RST); flush handshake = pipe_flush_req & pipe_flush_ack.
REQ-021 On flush handshake pc_r <= target, overriding any increment that cycle.
REQ-022 ifu_req_valid = (state == S_IDLE) & ~pipe_flush_req; ifu_req_pc = pc_r.
REQ-023 Request handshake (no flush): fetch_pc_r <= pc_r, pc_r <= pc_r + 4 (wraps modulo 2^`PC_SIZE), state -> S_WAIT.
REQ-024 S_RST: no request, no ack; -> S_IDLE next cycle unconditionally.
REQ-025 S_IDLE: flush handshake -> stay S_IDLE with new pc_r; request handshake -> S_WAIT; else hold.
REQ-026 S_WAIT: ifu_o_valid = ifu_rsp_valid & ~pipe_flush_req; ifu_rsp_ready = ifu_o_ready | pipe_flush_req; ifu_o_pc = fetch_pc_r; ifu_o_ir = ifu_rsp_instr.
REQ-027 S_WAIT, response handshake, no flush -> S_IDLE.
REQ-028 S_WAIT, flush with ifu_rsp_valid same cycle -> response consumed and dropped (ifu_o_valid=0), -> S_IDLE.
REQ-029 S_WAIT, flush without ifu_rsp_valid -> S_KILL.
REQ-030 S_KILL: ifu_o_valid = 0, ifu_rsp_ready = 1; ifu_rsp_valid -> S_IDLE; further flush handshakes update pc_r and stay S_KILL until response.
REQ-031 In S_RST, S_IDLE, S_KILL ifu_o_valid = 0; ifu_rsp_ready = 0 in S_RST and S_IDLE.
REQ-032 ifu_o_valid held while ifu_o_ready=0 with ifu_o_pc/ifu_o_ir stable (memory holds response until ready).
REQ-033 Response arriving in S_IDLE or S_RST is a protocol error; ignored, no state change.

Reset
REQ-034 Asserting rst_n=0 at any time (including mid-fetch or in S_KILL) immediately sets state=S_RST, pc_r=RESET_PC, fetch_pc_r=RESET_PC.
REQ-035 During and after reset until S_IDLE: ifu_req_valid=0, ifu_rsp_ready=0, ifu_o_valid=0, pipe_flush_ack=0; ifu_o_pc=RESET_PC.
REQ-036 Outstanding fetch at reset is abandoned; its late response ignored per REQ-033.

Verification
REQ-037 Reset release, RESET_PC=0x0, req_ready=1, rsp 1 cycle later, o_ready=1 -> req PCs 0x0,0x4,0x8; ifu_o_pc sequence 0x0,0x4,0x8.
REQ-038 S_WAIT with fetch_pc_r=0x10, flush op1=0x100 op2=0x20, rsp 2 cycles later -> ack=1, S_KILL, response dropped, next req_pc=0x120.
REQ-039 Flush coincident with rsp_valid in S_WAIT -> rsp_ready=1, o_valid=0, next state S_IDLE, next req_pc=target.
REQ-040 Two flushes in S_KILL (targets 0x200 then 0x300) -> next req_pc=0x300, exactly one response dropped.
REQ-041 pc_r=0xFFFF_FFFC (`PC_SIZE=32), op1=0xFFFF_FFF0 op2=0x20 -> target 0x10; increment from 0xFFFF_FFFC wraps to 0x0.
REQ-042 rst_n low during S_WAIT, o_ready=0 with rsp_valid held -> outputs reset immediately; after release first req_pc=RESET_PC.
